// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory program loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned DEPTH_DEF      = 32;
  localparam int unsigned ADDR_W_DEF     = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_FILL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; o_word_valid_c pulses with the 4th byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid_c,
  output logic [31:0] o_word_c
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] r_cnt;
  logic [23:0]      r_asm;

  // The top byte is never stored: it bypasses straight into the completed word.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_cnt <= '0;
      r_asm <= '0;
    end else if (i_byte_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
      case (r_cnt)
        CNT_W'(0): r_asm[7:0]   <= i_byte;
        CNT_W'(1): r_asm[15:8]  <= i_byte;
        CNT_W'(2): r_asm[23:16] <= i_byte;
        default:   r_asm        <= r_asm;
      endcase
    end
  end

  assign o_word_valid_c = i_byte_en && (r_cnt == CNT_W'(BYTES_PER_WORD - 1));
  assign o_word_c       = {i_byte, r_asm};

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction memory write port; holds the core in reset while loading.
// Define IMEM_LOADER_ZERO_FILL_EN to zero-fill the addresses beyond the loaded image.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              cpu_rst_n
);

  localparam int unsigned     CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
`ifdef IMEM_LOADER_ZERO_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  state_t              r_state;
  logic [CNT_W-1:0]    r_len_q;
  logic                r_byte_ready;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [31:0]         r_wr_data;
  logic [CNT_W-1:0]    r_word_count;
  logic                r_busy;
  logic                r_done;
  logic                r_cpu_rst_n;

  logic                w_start;
  logic                w_byte_en;
  logic                w_word_valid;
  logic [31:0]         w_word;
  logic [CNT_W-1:0]    w_wc_inc;

  assign w_start   = start && (r_state == ST_IDLE);
  assign w_byte_en = byte_valid && r_byte_ready;
  assign w_wc_inc  = r_word_count + CNT_W'(1);

  byte_packer u_packer (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clr          (w_start),
    .i_byte_en      (w_byte_en),
    .i_byte         (byte_data),
    .o_word_valid_c (w_word_valid),
    .o_word_c       (w_word)
  );

  // Session FSM; wr_addr saturates at the last word so it never wraps back to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_len_q      <= '0;
      r_byte_ready <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_word_count <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cpu_rst_n  <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len_q      <= (len > DEPTH_CNT) ? DEPTH_CNT : len;
            r_wr_addr    <= '0;
            r_word_count <= '0;
            r_done       <= 1'b0;
            r_cpu_rst_n  <= 1'b0;
            r_busy       <= 1'b1;
            if (len == '0) begin
              if (FILL_EN) begin
                r_state   <= ST_FILL;
                r_wr_en   <= 1'b1;
                r_wr_data <= '0;
              end else begin
                r_state <= ST_DONE;
              end
            end else begin
              r_state      <= ST_LOAD;
              r_byte_ready <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_word_valid) begin
            r_state      <= ST_WRITE;
            r_byte_ready <= 1'b0;
            r_wr_en      <= 1'b1;
            r_wr_data    <= w_word;
          end
        end
        ST_WRITE: begin
          r_word_count <= w_wc_inc;
          if (r_wr_addr != LAST_ADDR) r_wr_addr <= r_wr_addr + ADDR_W'(1);
          if (w_wc_inc == r_len_q) begin
            if (FILL_EN && (r_len_q != DEPTH_CNT)) begin
              r_state   <= ST_FILL;
              r_wr_en   <= 1'b1;
              r_wr_data <= '0;
            end else begin
              r_state <= ST_DONE;
            end
          end else begin
            r_state      <= ST_LOAD;
            r_byte_ready <= 1'b1;
          end
        end
        ST_FILL: begin
          r_word_count <= w_wc_inc;
          if (r_wr_addr == LAST_ADDR) begin
            r_state <= ST_DONE;
          end else begin
            r_wr_addr <= r_wr_addr + ADDR_W'(1);
            r_wr_en   <= 1'b1;
          end
        end
        ST_DONE: begin
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_cpu_rst_n <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign word_count = r_word_count;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cpu_rst_n  = r_cpu_rst_n;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table of load sessions plus reset/mid-session sequences.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;
`ifdef IMEM_LOADER_ZERO_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   word_count;
  logic          busy;
  logic          done;
  logic          cpu_rst_n;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .cpu_rst_n  (cpu_rst_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    bit            loaded;
  } exp_t;

  typedef struct {
    logic [AW:0] len;
    bit          toggle;
    bit          midstart;
    bit          gen;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb[$];
  exp_t        m_e;
  logic [7:0]  bq[$];
  logic [31:0] wq[$];
  logic [1:0]  bcnt;
  logic        acc4;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Tracks accepted bytes so a loaded write can be tied to the 4th byte one edge earlier.
  always @(posedge clk) begin
    if (!rst_n) begin
      bcnt <= 2'd0;
      acc4 <= 1'b0;
    end else begin
      acc4 <= byte_valid && byte_ready && (bcnt == 2'd3);
      if (byte_valid && byte_ready) bcnt <= bcnt + 2'd1;
    end
  end

  // Write monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", wr_addr, wr_data);
      end else begin
        m_e = sb.pop_front();
        if (wr_addr !== m_e.addr || wr_data !== m_e.data) begin
          n_fail++;
          $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                   wr_addr, wr_data, m_e.addr, m_e.data);
        end
        if (m_e.loaded) begin
          n_checks++;
          if (acc4 !== 1'b1) begin
            n_fail++;
            $display("FAIL write_latency: got addr=%0d without 4th byte on previous edge, expected 1-cycle latency",
                     wr_addr);
          end
        end
      end
    end
  end

  task automatic send_bytes(input bit toggle, input bit midstart);
    int i;
    int tries;
    i = 0;
    while (bq.size() > 0) begin
      byte_valid = 1'b1;
      byte_data  = bq[0];
      if (midstart && i == 3) begin
        start = 1'b1;
        len   = 6'd5;
      end
      tries = 0;
      while (byte_ready !== 1'b1 && tries < 50) begin
        @(posedge clk); #1;
        start = 1'b0;
        tries++;
      end
      if (tries >= 50) begin
        check("byte_ready_timeout", 64'(byte_ready), 64'd1);
        bq.delete();
      end else begin
        @(posedge clk); #1;
        start = 1'b0;
        void'(bq.pop_front());
        i++;
        if (toggle) begin
          byte_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic run_session(input logic [AW:0] l, input bit toggle, input bit midstart,
                             input int nloaded, output int cyc);
    for (int i = 0; i < nloaded; i++) sb.push_back('{AW'(i), wq[i], 1'b1});
    if (FILL)
      for (int i = nloaded; i < int'(DEPTH); i++) sb.push_back('{AW'(i), 32'h0, 1'b0});
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check("busy_rise", 64'(busy), 64'd1);
    check("done_cleared", 64'(done), 64'd0);
    check("cpu_rst_low", 64'(cpu_rst_n), 64'd0);
    send_bytes(toggle, midstart);
    while (done !== 1'b1 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("done_set", 64'(done), 64'd1);
    check("busy_fall", 64'(busy), 64'd0);
    check("cpu_rst_release", 64'(cpu_rst_n), 64'd1);
    check("word_count", 64'(word_count), FILL ? 64'(DEPTH) : 64'(nloaded));
    check("writes_outstanding", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[5];
    logic [7:0]  prog_b[8];
    logic [31:0] prog_w[2];
    int          nl;
    int          cyc;

    prog_b = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
    prog_w = '{32'h00500113, 32'h00C00193};
    vecs[0] = '{len: 6'd2,  toggle: 1'b0, midstart: 1'b0, gen: 1'b0};
    vecs[1] = '{len: 6'd2,  toggle: 1'b1, midstart: 1'b0, gen: 1'b0};
    vecs[2] = '{len: 6'd0,  toggle: 1'b0, midstart: 1'b0, gen: 1'b0};
    vecs[3] = '{len: 6'd40, toggle: 1'b0, midstart: 1'b0, gen: 1'b1};
    vecs[4] = '{len: 6'd2,  toggle: 1'b0, midstart: 1'b1, gen: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({byte_ready, wr_en, wr_addr, wr_data, word_count, busy, done, cpu_rst_n}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      bq.delete();
      wq.delete();
      nl = (int'(vecs[v].len) > int'(DEPTH)) ? int'(DEPTH) : int'(vecs[v].len);
      if (vecs[v].gen) begin
        for (int w = 0; w < nl; w++) begin
          wq.push_back({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
          for (int j = 0; j < 4; j++) bq.push_back(8'(4*w+j));
        end
      end else begin
        for (int w = 0; w < nl; w++) wq.push_back(prog_w[w]);
        for (int b = 0; b < 4*nl; b++) bq.push_back(prog_b[b]);
      end
      run_session(vecs[v].len, vecs[v].toggle, vecs[v].midstart, nl, cyc);
      if (vecs[v].len == '0) check("len0_done_latency", 64'(cyc), FILL ? 64'd34 : 64'd2);
      repeat (2) @(posedge clk);
      #1;
    end

    // Reset after two bytes of the second word, then a fresh one-word session.
    bq.delete();
    for (int b = 0; b < 6; b++) bq.push_back(prog_b[b]);
    sb.push_back('{AW'(0), 32'h00500113, 1'b1});
    start = 1'b1;
    len   = 6'd2;
    @(posedge clk); #1;
    start = 1'b0;
    send_bytes(1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midsession_reset_outputs",
          64'({byte_ready, wr_en, wr_addr, wr_data, word_count, busy, done, cpu_rst_n}), 64'd0);
    check("pre_reset_write_seen", 64'(sb.size()), 64'd0);
    sb.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    bq.delete();
    wq.delete();
    bq.push_back(8'h93); bq.push_back(8'h83); bq.push_back(8'h71); bq.push_back(8'hFF);
    wq.push_back(32'hFF718393);
    run_session(6'd1, 1'b0, 1'b0, 1, cyc);
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_write_after", 64'(wr_en), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
